// File: rtl/decode_issue_unit.sv
// Dual-issue decode stage: decodes an instruction pair, splits on intra-pair hazards and parks work in a pending register.
// Optional macro ILLEGAL_TRAP_EN adds a registered illegal_instr pulse for ops 9-15.
module decode_issue_unit #(
    parameter int DATA_W  = 16,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [INSTR_W-1:0] instr1,
    input  logic [INSTR_W-1:0] instr2,
    input  logic               is_branch_taken,
    input  logic               issue_stall,
    output logic               fetch_stall,
    output logic               s0_valid,
    output logic               s1_valid,
    output logic [3:0]         s0_op,
    output logic [3:0]         s1_op,
    output logic [2:0]         s0_dst,
    output logic [2:0]         s1_dst,
    output logic [2:0]         s0_src1,
    output logic [2:0]         s1_src1,
    output logic [2:0]         s0_src2,
    output logic [2:0]         s1_src2,
    output logic [DATA_W-1:0]  s0_imm,
    output logic [DATA_W-1:0]  s1_imm,
    output logic               s0_reg_write,
    output logic               s1_reg_write,
    output logic               s0_mem_read,
    output logic               s1_mem_read,
    output logic               s0_mem_write,
    output logic               s1_mem_write,
    output logic               s0_is_branch,
    output logic               s1_is_branch,
`ifdef ILLEGAL_TRAP_EN
    output logic               illegal_instr,
`endif
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_SPLIT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    typedef struct packed {
        logic              valid;
        logic [3:0]        op;
        logic [2:0]        dst;
        logic [2:0]        src1;
        logic [2:0]        src2;
        logic [DATA_W-1:0] imm;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              is_branch;
    } dec_t;

    // Unused source fields decode to 0 and r0 never writes, so hazard compares need no use-masks.
    function automatic dec_t decode(input logic [INSTR_W-1:0] ins);
        dec_t d;
        d     = '0;
        d.imm = {{(DATA_W-6){ins[5]}}, ins[5:0]};
        case (ins[15:12])
            4'd1, 4'd2, 4'd3, 4'd4: begin
                d.src1 = ins[8:6];
                d.src2 = ins[5:3];
            end
            4'd5, 4'd6: d.src1 = ins[8:6];
            4'd7: begin
                d.src1 = ins[8:6];
                d.src2 = ins[11:9];
            end
            4'd8: begin
                d.src1 = ins[11:9];
                d.src2 = ins[8:6];
            end
            default: ;
        endcase
        if (ins[15:12] >= 4'd1 && ins[15:12] <= 4'd8) begin
            d.valid = 1'b1;
            d.op    = ins[15:12];
        end
        if (ins[15:12] >= 4'd1 && ins[15:12] <= 4'd6) begin
            d.dst       = ins[11:9];
            d.reg_write = (ins[11:9] != 3'd0);
        end
        d.mem_read  = (ins[15:12] == 4'd6);
        d.mem_write = (ins[15:12] == 4'd7);
        d.is_branch = (ins[15:12] == 4'd8);
        return d;
    endfunction

    state_t             state_q;
    logic [INSTR_W-1:0] pend1_q, pend2_q;
    dec_t               s0_q, s1_q;
    logic [INSTR_W-1:0] cur1, cur2;
    dec_t               d1, d2;
    logic               split;
`ifdef ILLEGAL_TRAP_EN
    logic               illegal_q;
`endif

    // A lone split remainder sits in pend1 with pend2 as NOP, so it flows through the same pair path.
    assign cur1 = (state_q != ST_RUN) ? pend1_q : instr1;
    assign cur2 = (state_q != ST_RUN) ? pend2_q : instr2;
    assign d1   = decode(cur1);
    assign d2   = decode(cur2);

    assign split = d1.valid && d2.valid &&
                   ((d1.reg_write && (d1.dst == d2.src1 || d1.dst == d2.src2)) ||
                    (d1.reg_write && d2.reg_write && d1.dst == d2.dst) ||
                    ((d1.mem_read || d1.mem_write) && (d2.mem_read || d2.mem_write)) ||
                    d1.is_branch);

    assign fetch_stall = !is_branch_taken && (issue_stall || split);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_RUN;
            pend1_q   <= '0;
            pend2_q   <= '0;
            s0_q      <= '0;
            s1_q      <= '0;
`ifdef ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else if (is_branch_taken) begin
            state_q    <= ST_RUN;
            pend1_q    <= '0;
            pend2_q    <= '0;
            s0_q.valid <= 1'b0;
            s1_q.valid <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
            illegal_q  <= 1'b0;
`endif
        end else if (issue_stall) begin
            if (state_q == ST_RUN && (instr1 | instr2) != '0) begin
                pend1_q <= instr1;
                pend2_q <= instr2;
                state_q <= ST_HOLD;
            end
`ifdef ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else if (split) begin
            s0_q      <= d1;
            s1_q      <= '0;
            pend1_q   <= cur2;
            pend2_q   <= '0;
            state_q   <= ST_SPLIT;
`ifdef ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            s0_q      <= d1;
            s1_q      <= d2;
            pend1_q   <= '0;
            pend2_q   <= '0;
            state_q   <= ST_RUN;
`ifdef ILLEGAL_TRAP_EN
            illegal_q <= (cur1[15:12] >= 4'd9) || (cur2[15:12] >= 4'd9);
`endif
        end
    end

`ifdef ILLEGAL_TRAP_EN
    assign illegal_instr = illegal_q;
`endif
    assign dbg_state    = state_q;
    assign s0_valid     = s0_q.valid;
    assign s1_valid     = s1_q.valid;
    assign s0_op        = s0_q.op;
    assign s1_op        = s1_q.op;
    assign s0_dst       = s0_q.dst;
    assign s1_dst       = s1_q.dst;
    assign s0_src1      = s0_q.src1;
    assign s1_src1      = s1_q.src1;
    assign s0_src2      = s0_q.src2;
    assign s1_src2      = s1_q.src2;
    assign s0_imm       = s0_q.imm;
    assign s1_imm       = s1_q.imm;
    assign s0_reg_write = s0_q.reg_write;
    assign s1_reg_write = s1_q.reg_write;
    assign s0_mem_read  = s0_q.mem_read;
    assign s1_mem_read  = s1_q.mem_read;
    assign s0_mem_write = s0_q.mem_write;
    assign s1_mem_write = s1_q.mem_write;
    assign s0_is_branch = s0_q.is_branch;
    assign s1_is_branch = s1_q.is_branch;

endmodule

// File: doc/decode_issue_unit.md
Name: decode_issue_unit

Overview:
Dual-issue decode stage directly downstream of the fetch stage. Consumes the instruction pair `instr1`/`instr2` (instr1 older) each cycle and decodes both. Detects intra-pair hazards and issues through two registered issue slots. When a pair cannot be issued together, or the backend stalls, it drives `fetch_stall` and parks instructions in an internal pending register, so nothing fetch has already presented is lost.

Parameters:
- DATA_W, 16, width of the sign-extended immediate outputs.
- INSTR_W, 16, instruction width; only 16 is supported.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- instr1  in  16  older instruction from fetch; 0x0000 = NOP.
- instr2  in  16  younger instruction from fetch.
- is_branch_taken  in  1  flush; same signal that redirects fetch.
- issue_stall  in  1  backend cannot accept new slots this cycle.
- fetch_stall  out  1  combinational stall request to fetch.
- s0_valid, s1_valid  out  1  slot holds a live instruction (s0 older).
- s0_op, s1_op  out  4  opcode.
- s0_dst, s1_dst  out  3  destination register.
- s0_src1, s1_src1, s0_src2, s1_src2  out  3  source registers.
- s0_imm, s1_imm  out  DATA_W  sign-extended imm6.
- s0_reg_write, s1_reg_write, s0_mem_read, s1_mem_read, s0_mem_write, s1_mem_write, s0_is_branch, s1_is_branch  out  1  control.

Behaviour:
- Encoding: [15:12] op, [11:9] A, [8:6] B, [5:3] C, [5:0] imm6.
  - 0 NOP.
  - 1 ADD, 2 SUB, 3 AND, 4 OR: dst=A, src1=B, src2=C.
  - 5 ADDI: dst=A, src1=B.
  - 6 LW: dst=A, src1=B, mem_read.
  - 7 SW: src1=B, src2=A, mem_write.
  - 8 BEQ: src1=A, src2=B, is_branch.
  - 9-15 illegal; see Optional Feature.
  - Unused source fields output 0.
- Register writes:
  - reg_write=1 only for ops 1-6 with A!=0; r0 is hardwired zero.
  - Immediate: imm6 sign-extended to DATA_W for every op.
- Slot validity: valid=0 for a NOP; no compaction, so s1 may be valid while s0 is not.
- Split conditions, evaluated only when both instructions are live:
  - RAW: instr1 reg_write and its dst equals a used source of instr2.
  - WAW: both reg_write with the same dst.
  - Structural: both are memory ops.
  - Control: instr1 is BEQ.
- Latency: slot outputs are registered, 1 cycle after the pair is sampled.
- Current pair: the pending register if `pend_valid`, else the inputs. While `pend_valid` the inputs are ignored; fetch presents NOPs under stall.
- FSM states: RUN (no pending), SPLIT (pending holds lone instr2), HOLD (pending holds a full pair).
- Priority 1, `is_branch_taken`:
  - Next edge: both valids=0, pending cleared, state RUN.
  - `fetch_stall`=0.
  - Overrides `issue_stall`.
- Priority 2, `issue_stall`:
  - Slot outputs hold; `fetch_stall`=1.
  - RUN with a live input pair: capture the pair to pending and go to HOLD.
  - SPLIT/HOLD: remain.
- Priority 3, dual-issue OK:
  - Issue both slots, clear pending, state RUN.
  - `fetch_stall`=0.
- Priority 4, split needed:
  - Issue instr1 in s0; s1_valid=0.
  - Move instr2 to pending, state SPLIT, `fetch_stall`=1.
- SPLIT state: issue the pending instruction in s0, s1_valid=0, then go to RUN with `fetch_stall`=0. It never pairs with the next fetched instruction.
- HOLD state: the pending pair re-enters hazard check. It may split, going to SPLIT with `fetch_stall` kept at 1.
- Reset:
  - All outputs 0 and pending cleared, state RUN.
  - Reset asserted mid-split drops the pending instruction.

Optional Feature:
- Macro ILLEGAL_TRAP_EN.
- Enabled:
  - Adds output `illegal_instr` (1 bit, registered, reset 0).
  - Pulses for one cycle with the issue of any op 9-15, in either slot.
  - The illegal slot issues with valid=0.
  - Flush suppresses the pulse.
- Disabled: ops 9-15 decode silently as NOP and the port is absent.

Test Plan:
- 0x1298 / 0x1970 (ADD r1,r2,r3 ; ADD r4,r5,r6):
  - Next cycle s0_valid=s1_valid=1, s0_dst=1, s1_dst=4, `fetch_stall`=0.
- 0x1298 / 0x1870 (RAW on r1):
  - `fetch_stall`=1 that cycle.
  - Next cycle s0=ADD r1 only.
  - Following cycle s0_dst=4, s0_src1=1, s1_valid=0, `fetch_stall`=0.
- 0x62BF / 0x7702 (LW r1,[r2-1] ; SW r3,[r4+2]):
  - Structural split.
  - LW: s0_imm=0xFFFF, s0_mem_read=1.
  - SW next: s0_src2=3, s0_mem_write=1.
- `issue_stall`=1 for 3 cycles while 0x1298/0x1970 arrives:
  - Outputs frozen and `fetch_stall`=1 throughout.
  - After release both issue in one cycle, then the next input pair.
- Split in progress, then `is_branch_taken`=1:
  - Next cycle both valids=0, pending discarded.
  - `issue_stall` concurrently high does not block the flush.
- 0xF000 / 0x0000 with ILLEGAL_TRAP_EN:
  - `illegal_instr`=1 for one cycle, s0_valid=0.
  - Without the macro: no port, s0_valid=0.
